// File: rtl/port_alloc_last_rr_pkg.sv
// port_alloc_last_rr_pkg: shared router defaults and a clog2 constant function
package port_alloc_last_rr_pkg;
  localparam int NUM_PORT_DEF  = 5;
  localparam int LOCAL_IDX_DEF = 4;
  localparam int CNT_W_DEF     = 8;
  localparam int PORT_N = 0;
  localparam int PORT_E = 1;
  localparam int PORT_S = 2;
  localparam int PORT_W = 3;
  localparam int PORT_L = 4;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/port_alloc_last_rr_rr_pick.sv
// rr_pick: combinational round-robin pick, first set bit of req at or above ptr, wrapping
//   req [N-1:0]  candidate vector
//   ptr [PW-1:0] scan start index
//   gnt [N-1:0]  one-hot grant, zero when req is zero
//   idx [PW-1:0] encoded grant index
module rr_pick #(
  parameter int N  = 5,
  parameter int PW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);
  logic [PW-1:0] j;
  // Scan from the farthest offset down so the nearest hit to ptr wins last.
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = PW'((int'(ptr) + i) % N);
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end
endmodule

// File: rtl/port_alloc_last_rr.sv
// port_alloc_last_rr: registered last-stage BLESS port allocator with round-robin deflection
//   clk, reset (async active-low)
//   in_valid, req, avail   flit present, productive request, free ports
//   clr_cnt                synchronous clear of defl_cnt
//   alloc_valid, alloc     registered one-hot grant and its qualifier
//   deflected, no_port     grant is a deflection / flit had no legal port
//   defl_cnt               saturating deflection count, present only with PORT_ALLOC_STATS_EN
module port_alloc_last_rr
  import port_alloc_last_rr_pkg::*;
#(
  parameter int NUM_PORT  = NUM_PORT_DEF,
  parameter int LOCAL_IDX = LOCAL_IDX_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [NUM_PORT-1:0] req,
  input  logic [NUM_PORT-1:0] avail,
  input  logic                clr_cnt,
  output logic                alloc_valid,
  output logic [NUM_PORT-1:0] alloc,
  output logic                deflected,
  output logic                no_port,
  output logic [CNT_W-1:0]    defl_cnt
);
  localparam int PW = clog2(NUM_PORT) < 1 ? 1 : clog2(NUM_PORT);
  localparam logic [NUM_PORT-1:0] LOCAL_MASK = NUM_PORT'(1) << LOCAL_IDX;
  logic [NUM_PORT-1:0] prod, dset, prod_gnt, rr_gnt, alloc_d, alloc_q;
  logic [PW-1:0] rr_idx, ptr_d, ptr_q;
  logic defl, alloc_valid_d, alloc_valid_q, deflected_d, deflected_q, no_port_d, no_port_q;
  assign prod = req & avail;
  // The local port ejects only; it is never a deflection target.
  assign dset = avail & ~LOCAL_MASK;
  rr_pick #(.N(NUM_PORT), .PW(PW)) u_rr_pick (
    .req(dset),
    .ptr(ptr_q),
    .gnt(rr_gnt),
    .idx(rr_idx)
  );
  always_comb begin
    prod_gnt = '0;
    for (int i = 0; i < NUM_PORT; i++) if (prod[i]) prod_gnt = NUM_PORT'(1) << i;
    defl          = in_valid && prod == '0 && req != '0 && dset != '0;
    alloc_valid_d = in_valid;
    alloc_d       = !in_valid ? '0 : prod != '0 ? prod_gnt : defl ? rr_gnt : '0;
    deflected_d   = defl;
    no_port_d     = in_valid && prod == '0 && req != '0 && dset == '0;
    ptr_d         = !defl ? ptr_q : rr_idx == PW'(NUM_PORT - 1) ? '0 : rr_idx + 1'b1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alloc_valid_q <= 1'b0;
      alloc_q       <= '0;
      deflected_q   <= 1'b0;
      no_port_q     <= 1'b0;
      ptr_q         <= '0;
    end else begin
      alloc_valid_q <= alloc_valid_d;
      alloc_q       <= alloc_d;
      deflected_q   <= deflected_d;
      no_port_q     <= no_port_d;
      ptr_q         <= ptr_d;
    end
  end
  assign alloc_valid = alloc_valid_q;
  assign alloc       = alloc_q;
  assign deflected   = deflected_q;
  assign no_port     = no_port_q;
`ifdef PORT_ALLOC_STATS_EN
  logic [CNT_W-1:0] cnt_d, cnt_q;
  // Clear has priority over a coincident deflection.
  always_comb cnt_d = clr_cnt ? '0 : (defl && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign defl_cnt = cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clr_cnt;
  assign defl_cnt   = '0;
`endif
endmodule
